// File: rtl/fc_command_scheduler.sv
// fc_command_scheduler
//   Sequences and arbitrates fast-control commands ahead of the FC word
//   encoder, single clock domain (clk_bx).
//   - L1A path: software L1A merged with the calib-generated L1A, throttled by
//     a min-spacing holdoff and header FIFO occupancy; issued/dropped counted.
//   - Sync commands (link reset, buffer clear, calib pulse) are latched as
//     pending flags and issued one per orbit on the bx_id==sync_bx slot, by
//     priority link_reset > buf_clear > calib.
//   - A calib pulse arms a delay; its L1A reaches fc_l1a calib_offset BX
//     after the issue slot.
// Ports
//   clk_bx, reset_n                  clock, async active-low reset
//   enable                           gate for issuing any command
//   bx_id, sync_bx                   current BX / sync slot
//   req_*                            1-cycle requests
//   calib_offset, min_spacing        calib L1A delay, L1A holdoff
//   occupancy, occ_limit             header FIFO throttle
//   fc_*                             registered 1-cycle command bits
//   busy                             sync pending or calib L1A in flight
//   l1a_issued, l1a_dropped          counters (wrap / saturate)
module fc_command_scheduler #(
  parameter int ORB_W  = 12,
  parameter int OCC_W  = 8,
  parameter int CNT_W  = 32,
  parameter int DROP_W = 16
) (
  input  logic              clk_bx,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [ORB_W-1:0]  bx_id,
  input  logic [ORB_W-1:0]  sync_bx,
  input  logic              req_l1a,
  input  logic              req_link_reset,
  input  logic              req_buf_clear,
  input  logic              req_calib,
  input  logic [7:0]        calib_offset,
  input  logic [3:0]        min_spacing,
  input  logic [OCC_W-1:0]  occupancy,
  input  logic [OCC_W-1:0]  occ_limit,
  output logic              fc_l1a,
  output logic              fc_link_reset,
  output logic              fc_buf_clear,
  output logic              fc_calib,
  output logic              busy,
  output logic [CNT_W-1:0]  l1a_issued,
  output logic [DROP_W-1:0] l1a_dropped
);

  typedef enum logic [1:0] {IDLE, ARMED, CAL_WAIT} state_t;

  state_t     state, state_nxt;
  logic       pend_lr, pend_bc, pend_cal;
  logic [3:0] holdoff;
  logic [7:0] delay;

  logic slot, iss_lr, iss_bc, iss_cal, cal_req;
  logic l1a_req, l1a_ok, l1a_acc, l1a_drop;
  logic pend_lr_nxt, pend_bc_nxt, pend_cal_nxt, more_pend;

  // State register
  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Output/decode logic: issue selection and L1A acceptance
  always_comb begin
    slot     = (state == ARMED) && enable && (bx_id == sync_bx);
    iss_lr   = slot & pend_lr;
    iss_bc   = slot & ~pend_lr & pend_bc;
    iss_cal  = slot & ~pend_lr & ~pend_bc & pend_cal;
    // The L1A decision is made one cycle before fc_l1a: for offset 1 that is
    // the issue cycle itself, otherwise the cycle the delay steps from 2 to 1.
    cal_req  = (iss_cal && (calib_offset == 8'd1)) ||
               ((state == CAL_WAIT) && (delay == 8'd2));
    l1a_req  = req_l1a | cal_req;   // same-cycle requests merge into one
    l1a_ok   = enable && (holdoff == 4'd0) && (occupancy < occ_limit);
    l1a_acc  = l1a_req & l1a_ok;
    l1a_drop = l1a_req & ~l1a_ok;
    // A request on the clearing cycle re-sets its flag.
    pend_lr_nxt  = (pend_lr  & ~iss_lr)  | req_link_reset;
    pend_bc_nxt  = (pend_bc  & ~iss_bc)  | req_buf_clear;
    pend_cal_nxt = (pend_cal & ~iss_cal) | req_calib;
    more_pend    = pend_lr_nxt | pend_bc_nxt | pend_cal_nxt;
    busy         = (state != IDLE) | pend_lr | pend_bc | pend_cal;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (enable && (pend_lr || pend_bc || pend_cal)) state_nxt = ARMED;
      ARMED:
        if (!enable)                             state_nxt = IDLE;
        else if (iss_cal && calib_offset > 8'd1) state_nxt = CAL_WAIT;
        else if (iss_lr || iss_bc || iss_cal)    state_nxt = more_pend ? ARMED : IDLE;
      CAL_WAIT:
        // delay<=2 also covers a stray value so the FSM can never stick here
        if (delay <= 8'd2) state_nxt = more_pend ? ARMED : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Flags, timers, counters and registered command bits
  always_ff @(posedge clk_bx or negedge reset_n) begin
    if (!reset_n) begin
      pend_lr       <= 1'b0;
      pend_bc       <= 1'b0;
      pend_cal      <= 1'b0;
      holdoff       <= '0;
      delay         <= '0;
      l1a_issued    <= '0;
      l1a_dropped   <= '0;
      fc_l1a        <= 1'b0;
      fc_link_reset <= 1'b0;
      fc_buf_clear  <= 1'b0;
      fc_calib      <= 1'b0;
    end else begin
      pend_lr  <= pend_lr_nxt;
      pend_bc  <= pend_bc_nxt;
      pend_cal <= pend_cal_nxt;

      if (l1a_acc)                holdoff <= min_spacing;
      else if (holdoff != 4'd0)   holdoff <= holdoff - 4'd1;

      if (iss_cal)                                    delay <= calib_offset;
      else if (state == CAL_WAIT && delay != 8'd0)    delay <= delay - 8'd1;

      if (l1a_acc)                    l1a_issued  <= l1a_issued + 1'b1;
      if (l1a_drop && ~&l1a_dropped)  l1a_dropped <= l1a_dropped + 1'b1;

      fc_l1a        <= l1a_acc;
      fc_link_reset <= iss_lr;
      fc_buf_clear  <= iss_bc;
      fc_calib      <= iss_cal;
    end
  end

endmodule

// File: tb/tb_fc_command_scheduler.sv
module tb_fc_command_scheduler;
  localparam int ORB_W = 12, OCC_W = 8, CNT_W = 32, DROP_W = 16;
  localparam int ORBIT = 40;

  logic              clk_bx = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [ORB_W-1:0]  bx_id = '0;
  logic [ORB_W-1:0]  sync_bx = '0;
  logic              req_l1a = 1'b0, req_link_reset = 1'b0, req_buf_clear = 1'b0, req_calib = 1'b0;
  logic [7:0]        calib_offset = '0;
  logic [3:0]        min_spacing = '0;
  logic [OCC_W-1:0]  occupancy = '0, occ_limit = '0;
  logic              fc_l1a, fc_link_reset, fc_buf_clear, fc_calib, busy;
  logic [CNT_W-1:0]  l1a_issued;
  logic [DROP_W-1:0] l1a_dropped;

  int n_chk = 0, n_fail = 0;

  fc_command_scheduler #(.ORB_W(ORB_W), .OCC_W(OCC_W), .CNT_W(CNT_W), .DROP_W(DROP_W)) dut (
    .clk_bx(clk_bx), .reset_n(reset_n), .enable(enable), .bx_id(bx_id), .sync_bx(sync_bx),
    .req_l1a(req_l1a), .req_link_reset(req_link_reset), .req_buf_clear(req_buf_clear),
    .req_calib(req_calib), .calib_offset(calib_offset), .min_spacing(min_spacing),
    .occupancy(occupancy), .occ_limit(occ_limit), .fc_l1a(fc_l1a), .fc_link_reset(fc_link_reset),
    .fc_buf_clear(fc_buf_clear), .fc_calib(fc_calib), .busy(busy),
    .l1a_issued(l1a_issued), .l1a_dropped(l1a_dropped));

  always #5 clk_bx = ~clk_bx;

  // free-running orbit counter
  always @(posedge clk_bx)
    bx_id <= (bx_id == ORB_W'(ORBIT - 1)) ? '0 : bx_id + 12'd1;

  task automatic apply_reset();
    @(negedge clk_bx);
    reset_n = 1'b0;
    enable = 1'b0; req_l1a = 1'b0; req_link_reset = 1'b0; req_buf_clear = 1'b0; req_calib = 1'b0;
    sync_bx = '0; calib_offset = '0; min_spacing = '0; occupancy = '0; occ_limit = 8'd8;
    repeat (2) @(negedge clk_bx);
    reset_n = 1'b1;
  endtask

  // advance to the negedge where bx_id==v (bounded)
  task automatic wait_bx(input int v, input string nm);
    int t = 0;
    do begin @(negedge clk_bx); t++; end while (int'(bx_id) != v && t < 2 * ORBIT);
    if (int'(bx_id) != v) begin
      n_chk++; n_fail++;
      $display("FAIL %s: timeout waiting for bx %0d, at bx %0d", nm, v, bx_id);
    end
  endtask

  task automatic test_reset();
    @(negedge clk_bx);
    reset_n = 1'b0;
    #1;
    n_chk++; if ({fc_l1a, fc_link_reset, fc_buf_clear, fc_calib} !== 4'b0) begin n_fail++;
      $display("FAIL reset_fc: got %b want 0000", {fc_l1a, fc_link_reset, fc_buf_clear, fc_calib}); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (l1a_issued !== '0) begin n_fail++; $display("FAIL reset_issued: got %0d want 0", l1a_issued); end
    n_chk++; if (l1a_dropped !== '0) begin n_fail++; $display("FAIL reset_dropped: got %0d want 0", l1a_dropped); end
  endtask

  task automatic test_l1a_spacing();
    logic exp;
    apply_reset();
    enable = 1'b1; min_spacing = 4'd4;
    wait_bx(9, "spacing");
    for (int b = 10; b <= 17; b++) begin
      @(negedge clk_bx);
      exp = (b == 11) || (b == 16);
      n_chk++; if (fc_l1a !== exp) begin n_fail++;
        $display("FAIL spacing_fc_l1a bx%0d: got %b want %b", b, fc_l1a, exp); end
      req_l1a = (b == 10) || (b == 12) || (b == 15);
    end
    n_chk++; if (l1a_issued !== 32'd2) begin n_fail++; $display("FAIL spacing_issued: got %0d want 2", l1a_issued); end
    n_chk++; if (l1a_dropped !== 16'd1) begin n_fail++; $display("FAIL spacing_dropped: got %0d want 1", l1a_dropped); end
  endtask

  task automatic test_occupancy();
    apply_reset();
    enable = 1'b1; occupancy = 8'd8; occ_limit = 8'd8;
    req_l1a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_bx);
      if (i == 2) req_l1a = 1'b0;
      n_chk++; if (fc_l1a !== 1'b0) begin n_fail++; $display("FAIL occ_full_fc_l1a %0d: got %b want 0", i, fc_l1a); end
    end
    n_chk++; if (l1a_dropped !== 16'd3) begin n_fail++; $display("FAIL occ_dropped: got %0d want 3", l1a_dropped); end
    occupancy = 8'd7; req_l1a = 1'b1;
    @(negedge clk_bx); req_l1a = 1'b0;
    n_chk++; if (fc_l1a !== 1'b1) begin n_fail++; $display("FAIL occ_below_fc_l1a: got %b want 1", fc_l1a); end
    @(negedge clk_bx);
    n_chk++; if (fc_l1a !== 1'b0) begin n_fail++; $display("FAIL occ_pulse_width: got %b want 0", fc_l1a); end
    n_chk++; if (l1a_issued !== 32'd1) begin n_fail++; $display("FAIL occ_issued: got %0d want 1", l1a_issued); end
  endtask

  task automatic test_sync_priority();
    int lr_n = 0, bc_n = 0, lr_bx = -1, bc_bx = -1, lr_c = 0, bc_c = 0;
    apply_reset();
    enable = 1'b1; sync_bx = 12'd5;
    wait_bx(20, "sync");
    req_link_reset = 1'b1; req_buf_clear = 1'b1;
    @(negedge clk_bx);
    req_link_reset = 1'b0; req_buf_clear = 1'b0;
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL sync_busy_pending: got %b want 1", busy); end
    for (int c = 1; c <= 2 * ORBIT; c++) begin
      if (fc_link_reset) begin lr_n++; lr_bx = int'(bx_id); lr_c = c; end
      if (fc_buf_clear)  begin bc_n++; bc_bx = int'(bx_id); bc_c = c; end
      @(negedge clk_bx);
    end
    n_chk++; if (lr_n != 1) begin n_fail++; $display("FAIL sync_lr_count: got %0d want 1", lr_n); end
    n_chk++; if (bc_n != 1) begin n_fail++; $display("FAIL sync_bc_count: got %0d want 1", bc_n); end
    n_chk++; if (lr_bx != 6) begin n_fail++; $display("FAIL sync_lr_bx: got %0d want 6", lr_bx); end
    n_chk++; if (bc_bx != 6) begin n_fail++; $display("FAIL sync_bc_bx: got %0d want 6", bc_bx); end
    n_chk++; if (bc_c - lr_c != ORBIT) begin n_fail++; $display("FAIL sync_bc_gap: got %0d want %0d", bc_c - lr_c, ORBIT); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sync_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_calib();
    int cal_n = 0, l1a_n = 0, cal_bx = -1, l1a_bx = -1;
    bit merged = 0;
    apply_reset();
    enable = 1'b1; sync_bx = 12'd0; calib_offset = 8'd20;
    wait_bx(30, "calib");
    req_calib = 1'b1;
    @(negedge clk_bx);
    req_calib = 1'b0;
    for (int c = 0; c < 2 * ORBIT; c++) begin
      if (fc_calib) begin cal_n++; cal_bx = int'(bx_id); end
      if (fc_l1a)   begin l1a_n++; l1a_bx = int'(bx_id); end
      // software L1A on the same cycle as the calib L1A decision
      if (cal_n == 1 && !merged && bx_id == 12'd19) begin
        merged = 1; req_l1a = 1'b1;
        n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL calib_busy_inflight: got %b want 1", busy); end
      end else req_l1a = 1'b0;
      @(negedge clk_bx);
    end
    n_chk++; if (cal_n != 1) begin n_fail++; $display("FAIL calib_count: got %0d want 1", cal_n); end
    n_chk++; if (cal_bx != 1) begin n_fail++; $display("FAIL calib_bx: got %0d want 1", cal_bx); end
    n_chk++; if (l1a_n != 1) begin n_fail++; $display("FAIL calib_l1a_count: got %0d want 1", l1a_n); end
    n_chk++; if (l1a_bx != 20) begin n_fail++; $display("FAIL calib_l1a_bx: got %0d want 20", l1a_bx); end
    n_chk++; if (l1a_issued !== 32'd1) begin n_fail++; $display("FAIL calib_merge_issued: got %0d want 1", l1a_issued); end
    n_chk++; if (l1a_dropped !== 16'd0) begin n_fail++; $display("FAIL calib_merge_dropped: got %0d want 0", l1a_dropped); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL calib_busy_done: got %b want 0", busy); end
  endtask

  task automatic test_enable_gate();
    int lr_n = 0, l1a_n = 0;
    apply_reset();
    sync_bx = 12'd5;
    wait_bx(10, "enable");
    req_link_reset = 1'b1; req_l1a = 1'b1;
    @(negedge clk_bx);
    req_link_reset = 1'b0; req_l1a = 1'b0;
    for (int c = 0; c < ORBIT + 2; c++) begin
      if (fc_link_reset) lr_n++;
      if (fc_l1a) l1a_n++;
      @(negedge clk_bx);
    end
    n_chk++; if (lr_n != 0 || l1a_n != 0) begin n_fail++;
      $display("FAIL enable_off_pulses: got lr=%0d l1a=%0d want 0 0", lr_n, l1a_n); end
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL enable_off_busy: got %b want 1", busy); end
    n_chk++; if (l1a_dropped !== 16'd1) begin n_fail++; $display("FAIL enable_off_dropped: got %0d want 1", l1a_dropped); end
    enable = 1'b1;
    wait_bx(6, "enable_on");
    n_chk++; if (fc_link_reset !== 1'b1) begin n_fail++; $display("FAIL enable_on_lr: got %b want 1", fc_link_reset); end
  endtask

  task automatic test_drop_saturate();
    apply_reset();
    enable = 1'b1; occupancy = 8'd8; occ_limit = 8'd8;
    req_l1a = 1'b1;
    repeat (65534) @(negedge clk_bx);
    n_chk++; if (l1a_dropped !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: got %h want fffe", l1a_dropped); end
    repeat (3) @(negedge clk_bx);
    req_l1a = 1'b0;
    n_chk++; if (l1a_dropped !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold: got %h want ffff", l1a_dropped); end
    n_chk++; if (l1a_issued !== 32'd0) begin n_fail++; $display("FAIL sat_issued: got %0d want 0", l1a_issued); end
  endtask

  task automatic test_reset_cal_wait();
    int pulses = 0;
    apply_reset();
    enable = 1'b1; sync_bx = 12'd0; calib_offset = 8'd20;
    wait_bx(30, "rst_cal");
    req_calib = 1'b1;
    @(negedge clk_bx);
    req_calib = 1'b0;
    wait_bx(5, "rst_cal_wait");
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstcal_busy_before: got %b want 1", busy); end
    reset_n = 1'b0;
    #1;
    n_chk++; if ({fc_l1a, fc_link_reset, fc_buf_clear, fc_calib, busy} !== 5'b0) begin n_fail++;
      $display("FAIL rstcal_outputs: got %b want 00000", {fc_l1a, fc_link_reset, fc_buf_clear, fc_calib, busy}); end
    @(negedge clk_bx);
    reset_n = 1'b1;
    for (int c = 0; c < 2 * ORBIT; c++) begin
      if (fc_l1a || fc_calib) pulses++;
      @(negedge clk_bx);
    end
    n_chk++; if (pulses != 0) begin n_fail++; $display("FAIL rstcal_no_l1a: got %0d pulses want 0", pulses); end
    n_chk++; if (l1a_issued !== 32'd0) begin n_fail++; $display("FAIL rstcal_issued: got %0d want 0", l1a_issued); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstcal_busy_after: got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_l1a_spacing();
    test_occupancy();
    test_sync_priority();
    test_calib();
    test_enable_gate();
    test_drop_saturate();
    test_reset_cal_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
